// File: rtl/sram_wbuf.sv
// sram_wbuf: banked synchronous work RAM with one read port and two write
// sources. Debug writes always win the array; a CPU write that collides is
// queued in a small in-order buffer. The CPU is stalled only when that buffer
// is full.
module sram_wbuf #(
    parameter int DWIDTH  = 16,
    parameter int BANK_AW = 8,
    parameter int NBANKS  = 2,
    parameter int WBDEPTH = 2,
    parameter int RDW_NEW = 0,
    parameter int BYPASS  = 1,
    localparam int AW     = BANK_AW + $clog2(NBANKS),
    localparam int CW     = $clog2(WBDEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_we,
    input  logic [AW-1:0]     dbg_waddr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_waddr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_wstall,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic [CW-1:0]     wb_count
);

    // Bank-select and buffer-index widths never drop to zero, even for a
    // single bank or a single-entry buffer.
    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int PW = (WBDEPTH > 1) ? $clog2(WBDEPTH) : 1;

    // Write buffer: entry 0 is always the oldest (head); pops shift down.
    logic [AW-1:0]     r_wb_addr [WBDEPTH];
    logic [DWIDTH-1:0] r_wb_data [WBDEPTH];
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_cpu_acc;
    logic              w_commit;
    logic              w_pop;
    logic              w_push;
    logic [AW-1:0]     w_caddr;
    logic [DWIDTH-1:0] w_cdata;
    logic [PW-1:0]     w_push_idx;
    logic [BW-1:0]     w_cbank;
    logic [BW-1:0]     w_rbank;
    logic [NBANKS-1:0] w_bank_we;
    logic [DWIDTH-1:0] w_bank_q [NBANKS];
    logic              w_fwd_hit;
    logic [DWIDTH-1:0] w_fwd_data;

    logic              r_rvalid;
    logic              r_zero;
    logic              r_use_fwd;
    logic [BW-1:0]     r_rd_bank;
    logic [DWIDTH-1:0] r_fwd_data;

    assign w_full     = (r_count == CW'(WBDEPTH));
    assign cpu_wstall = w_full;
    assign w_cpu_acc  = cpu_we & ~w_full;
    assign wb_count   = r_count;

    // Pick the single array write for this cycle: debug, then buffer head,
    // then a direct CPU write when nothing else is waiting.
    always_comb begin
        w_commit = 1'b0;
        w_pop    = 1'b0;
        w_push   = 1'b0;
        w_caddr  = dbg_waddr;
        w_cdata  = dbg_wdata;
        if (dbg_we) begin
            w_commit = 1'b1;
            w_push   = w_cpu_acc;
        end else if (r_count != '0) begin
            w_commit = 1'b1;
            w_caddr  = r_wb_addr[0];
            w_cdata  = r_wb_data[0];
            w_pop    = 1'b1;
            w_push   = w_cpu_acc;
        end else if (w_cpu_acc) begin
            w_commit = 1'b1;
            w_caddr  = cpu_waddr;
            w_cdata  = cpu_wdata;
        end
    end

    // A push in the same cycle as a pop lands one slot lower because the
    // queue shifts down underneath it.
    assign w_push_idx = PW'(w_pop ? (r_count - 1'b1) : r_count);

    if (NBANKS > 1) begin : g_bsel
        assign w_cbank = w_caddr[AW-1:BANK_AW];
        assign w_rbank = raddr[AW-1:BANK_AW];
    end else begin : g_bsel_one
        assign w_cbank = '0;
        assign w_rbank = '0;
    end

    // One-hot bank write enable; a write in the reset cycle is dropped.
    always_comb begin
        w_bank_we = '0;
        for (int b = 0; b < NBANKS; b++) begin
            w_bank_we[b] = w_commit & ~reset & (w_cbank == BW'(b));
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DWIDTH-1:0] r_mem [2**BANK_AW];
        logic [DWIDTH-1:0] r_q;

        // Read-before-write bank array with registered read port.
        always_ff @(posedge clk) begin
            if (w_bank_we[b]) begin
                r_mem[w_caddr[BANK_AW-1:0]] <= w_cdata;
            end
            if (re) begin
                r_q <= r_mem[raddr[BANK_AW-1:0]];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    // Forwarding source: same-cycle commit data (new-data mode), overridden
    // by the newest pending buffer entry for this address.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = w_cdata;
        if ((RDW_NEW != 0) && w_commit && (w_caddr == raddr)) begin
            w_fwd_hit = 1'b1;
        end
        if (BYPASS != 0) begin
            for (int i = 0; i < WBDEPTH; i++) begin
                if ((CW'(i) < r_count) && (r_wb_addr[i] == raddr)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_wb_data[i];
                end
            end
        end
    end

    // Write-buffer occupancy; pending entries are simply forgotten on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Write-buffer storage: shift on pop, store at tail on push.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int i = 0; i < WBDEPTH - 1; i++) begin
                r_wb_addr[i] <= r_wb_addr[i+1];
                r_wb_data[i] <= r_wb_data[i+1];
            end
        end
        if (w_push) begin
            r_wb_addr[w_push_idx] <= cpu_waddr;
            r_wb_data[w_push_idx] <= cpu_wdata;
        end
    end

    // Read-side select registers; r_zero forces rdata to 0 until the first read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid   <= 1'b0;
            r_zero     <= 1'b1;
            r_use_fwd  <= 1'b0;
            r_rd_bank  <= '0;
            r_fwd_data <= '0;
        end else begin
            r_rvalid <= re;
            if (re) begin
                r_zero     <= 1'b0;
                r_use_fwd  <= w_fwd_hit;
                r_fwd_data <= w_fwd_data;
                r_rd_bank  <= w_rbank;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_zero    ? '0 :
                    r_use_fwd ? r_fwd_data : w_bank_q[r_rd_bank];

endmodule

// File: tb/tb_sram_wbuf.sv
// Bench for sram_wbuf: two instances share stimulus, one with defaults
// (bypass on, old-data RDW) and one with bypass off and new-data RDW.
module tb_sram_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_we;
    logic [8:0]  dbg_waddr;
    logic [15:0] dbg_wdata;
    logic        cpu_we;
    logic [8:0]  cpu_waddr;
    logic [15:0] cpu_wdata;
    logic        re;
    logic [8:0]  raddr;
    logic        stall0, stall1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  count0, count1;

    always #5 clk = ~clk;

    sram_wbuf u_dut0 (
        .clk(clk), .reset(reset),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_wstall(stall0), .re(re), .raddr(raddr),
        .rdata(rdata0), .rvalid(rvalid0), .wb_count(count0)
    );

    sram_wbuf #(.RDW_NEW(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_wstall(stall1), .re(re), .raddr(raddr),
        .rdata(rdata1), .rvalid(rvalid1), .wb_count(count1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: memory contents plus an ordered list of pending CPU writes.
    typedef struct packed {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         m_q[$];
    logic [15:0] m_mem [512];
    logic        act_stall;
    logic [1:0]  act_count;
    logic        exp_stall;
    logic [1:0]  exp_count;
    logic        exp_rvalid;
    logic [15:0] exp_rd0 = '0;
    logic [15:0] exp_rd1 = '0;

    function automatic logic [15:0] init_val(input logic [8:0] a);
        return 16'h3C00 ^ {7'd0, a};
    endfunction

    function automatic logic [8:0] rnd_addr();
        return {1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15))};
    endfunction

    // One clock: drive inputs, sample pre-edge status, advance the model.
    task automatic step(input logic d_we, input logic [8:0] d_a, input logic [15:0] d_d,
                        input logic c_we, input logic [8:0] c_a, input logic [15:0] c_d,
                        input logic r_e, input logic [8:0] r_a);
        logic        acc, cm;
        logic [8:0]  ca;
        logic [15:0] cd;
        dbg_we = d_we; dbg_waddr = d_a; dbg_wdata = d_d;
        cpu_we = c_we; cpu_waddr = c_a; cpu_wdata = c_d;
        re = r_e; raddr = r_a;
        act_stall = stall0;
        act_count = count0;
        exp_stall = (m_q.size() == 2);
        exp_count = 2'(m_q.size());
        acc = c_we && !exp_stall;
        cm = 1'b1; ca = d_a; cd = d_d;
        if (d_we) begin
            ca = d_a; cd = d_d;
        end else if (m_q.size() > 0) begin
            ca = m_q[0].a; cd = m_q[0].d;
        end else if (acc) begin
            ca = c_a; cd = c_d;
        end else begin
            cm = 1'b0;
        end
        if (r_e) begin
            exp_rd0 = m_mem[r_a];
            foreach (m_q[i]) if (m_q[i].a == r_a) exp_rd0 = m_q[i].d;
            exp_rd1 = (cm && ca == r_a) ? cd : m_mem[r_a];
        end
        exp_rvalid = r_e;
        @(posedge clk); #1;
        if (cm) m_mem[ca] = cd;
        if (!d_we && m_q.size() > 0) void'(m_q.pop_front());
        if (acc && (d_we || exp_count != 2'd0)) m_q.push_back('{a: c_a, d: c_d});
    endtask

    task automatic idle();
        step(1'b0, 9'd0, 16'd0, 1'b0, 9'd0, 16'd0, 1'b0, 9'd0);
    endtask

    task automatic rd(input logic [8:0] a);
        step(1'b0, 9'd0, 16'd0, 1'b0, 9'd0, 16'd0, 1'b1, a);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dbg_we = 0; dbg_waddr = 0; dbg_wdata = 0;
        cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0; re = 0; raddr = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count0); end
        checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall0); end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
        checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0000", rdata0, rdata1); end
        reset = 1'b0;
        m_q.delete();
        for (int a = 0; a < 512; a++) step(1'b1, 9'(a), init_val(9'(a)), 1'b0, 9'd0, 16'd0, 1'b0, 9'd0);
    endtask

    task automatic test_direct();
        step(1'b0, 9'd0, 16'd0, 1'b1, 9'h005, 16'h1234, 1'b0, 9'd0);
        rd(9'h005);
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL direct_count got=%0d exp=0", count0); end
        checks++; if (rvalid0 !== 1'b1) begin failures++; $display("FAIL direct_rvalid got=%b exp=1", rvalid0); end
        checks++; if (rdata0 !== 16'h1234 || rdata1 !== 16'h1234) begin failures++; $display("FAIL direct_rdata got=%h/%h exp=1234", rdata0, rdata1); end
        idle();
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h1234) begin failures++; $display("FAIL direct_hold got=%b/%h exp=0/1234", rvalid0, rdata0); end
    endtask

    task automatic test_collision();
        step(1'b1, 9'h010, 16'h0AAA, 1'b1, 9'h010, 16'h0BBB, 1'b0, 9'd0);
        checks++; if (count0 !== 2'd1) begin failures++; $display("FAIL coll_count got=%0d exp=1", count0); end
        idle();
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL coll_drain got=%0d exp=0", count0); end
        rd(9'h010);
        checks++; if (rdata0 !== 16'h0BBB || rdata1 !== 16'h0BBB) begin failures++; $display("FAIL coll_rdata got=%h/%h exp=0bbb", rdata0, rdata1); end
    endtask

    task automatic test_fill_stall();
        logic [6:0] stall_pat = 7'b0011100;
        int idx = 0;
        for (int c = 0; c < 7; c++) begin
            step(c < 4, 9'h1F0, 16'hD000 + 16'(c), idx < 3, 9'h100 + 9'(idx), 16'hA100 + 16'(idx), 1'b0, 9'd0);
            checks++;
            if (act_stall !== stall_pat[c]) begin failures++; $display("FAIL fill_stall_c%0d got=%b exp=%b", c, act_stall, stall_pat[c]); end
            if (c == 2) begin
                checks++; if (act_count !== 2'd2) begin failures++; $display("FAIL fill_count got=%0d exp=2", act_count); end
            end
            if (idx < 3 && !exp_stall) idx++;
        end
        for (int k = 0; k < 4 && count0 != 2'd0; k++) idle();
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL fill_drain got=%0d exp=0", count0); end
        for (int i = 0; i < 3; i++) begin
            rd(9'h100 + 9'(i));
            checks++;
            if (rdata0 !== 16'hA100 + 16'(i)) begin failures++; $display("FAIL fill_rd%0d got=%h exp=%h", i, rdata0, 16'hA100 + 16'(i)); end
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 9'h1F1, 16'h1111, 1'b1, 9'h0C0, 16'h5555, 1'b0, 9'd0);
        step(1'b1, 9'h1F1, 16'h2222, 1'b0, 9'd0, 16'd0, 1'b1, 9'h0C0);
        checks++; if (count0 !== 2'd1) begin failures++; $display("FAIL byp_count got=%0d exp=1", count0); end
        checks++; if (rdata0 !== 16'h5555) begin failures++; $display("FAIL byp_on got=%h exp=5555", rdata0); end
        checks++; if (rdata1 !== init_val(9'h0C0)) begin failures++; $display("FAIL byp_off got=%h exp=%h", rdata1, init_val(9'h0C0)); end
        idle();
        rd(9'h0C0);
        checks++; if (rdata0 !== 16'h5555 || rdata1 !== 16'h5555) begin failures++; $display("FAIL byp_final got=%h/%h exp=5555", rdata0, rdata1); end
    endtask

    task automatic test_rdw();
        step(1'b1, 9'h020, 16'h1111, 1'b0, 9'd0, 16'd0, 1'b0, 9'd0);
        step(1'b0, 9'd0, 16'd0, 1'b1, 9'h020, 16'h7777, 1'b1, 9'h020);
        checks++; if (rdata0 !== 16'h1111) begin failures++; $display("FAIL rdw_old got=%h exp=1111", rdata0); end
        checks++; if (rdata1 !== 16'h7777) begin failures++; $display("FAIL rdw_new got=%h exp=7777", rdata1); end
        rd(9'h020);
        checks++; if (rdata0 !== 16'h7777) begin failures++; $display("FAIL rdw_after got=%h exp=7777", rdata0); end
    endtask

    task automatic test_reset_mid_drain();
        step(1'b1, 9'h1F2, 16'hD100, 1'b1, 9'h030, 16'hB030, 1'b0, 9'd0);
        step(1'b1, 9'h1F2, 16'hD101, 1'b1, 9'h031, 16'hB031, 1'b1, 9'h031);
        checks++; if (count0 !== 2'd2) begin failures++; $display("FAIL rst_pre_count got=%0d exp=2", count0); end
        reset = 1'b1;
        dbg_we = 1'b1; dbg_waddr = 9'h032; dbg_wdata = 16'hEEEE;
        cpu_we = 1'b1; cpu_waddr = 9'h033; cpu_wdata = 16'hFFFF; re = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; dbg_we = 1'b0; cpu_we = 1'b0;
        m_q.delete(); exp_rd0 = '0; exp_rd1 = '0;
        checks++; if (count0 !== 2'd0 || stall0 !== 1'b0) begin failures++; $display("FAIL rst_mid_count got=%0d/%b exp=0/0", count0, stall0); end
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h0 || rdata1 !== 16'h0) begin failures++; $display("FAIL rst_mid_rd got=%b/%h/%h exp=0/0/0", rvalid0, rdata0, rdata1); end
        for (int i = 0; i < 4; i++) begin
            rd(9'h030 + 9'(i));
            checks++;
            if (rdata0 !== init_val(9'h030 + 9'(i))) begin failures++; $display("FAIL rst_keep%0d got=%h exp=%h", i, rdata0, init_val(9'h030 + 9'(i))); end
        end
    endtask

    task automatic test_random();
        logic        pend = 1'b0;
        logic [8:0]  pa = '0;
        logic [15:0] pd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && $urandom_range(0, 9) < 6) begin
                pend = 1'b1; pa = rnd_addr(); pd = 16'($urandom);
            end
            step($urandom_range(0, 9) < 3, rnd_addr(), 16'($urandom), pend, pa, pd,
                 1'($urandom_range(0, 1)), rnd_addr());
            if (pend && !exp_stall) pend = 1'b0;
            checks++; if (act_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, act_stall, exp_stall); end
            checks++; if (act_count !== exp_count) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, act_count, exp_count); end
            checks++; if (rvalid0 !== exp_rvalid || rvalid1 !== exp_rvalid) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%b%b exp=%b", n, rvalid0, rvalid1, exp_rvalid); end
            checks++; if (rdata0 !== exp_rd0) begin failures++; $display("FAIL rnd_rdata0 n=%0d got=%h exp=%h", n, rdata0, exp_rd0); end
            checks++; if (rdata1 !== exp_rd1) begin failures++; $display("FAIL rnd_rdata1 n=%0d got=%h exp=%h", n, rdata1, exp_rd1); end
            checks++; if (count1 !== count0 + 2'd0 || stall1 !== (count1 == 2'd2)) begin failures++; $display("FAIL rnd_dut1_wb n=%0d got=%0d/%b exp=%0d", n, count1, stall1, count0); end
        end
        for (int k = 0; k < 4; k++) idle();
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", count0); end
        for (int a = 0; a < 16; a++) begin
            rd({1'b1, 4'd0, 4'(a)});
            checks++; if (rdata0 !== exp_rd0) begin failures++; $display("FAIL rnd_final a=%0d got=%h exp=%h", a, rdata0, exp_rd0); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_collision();
        test_fill_stall();
        test_bypass();
        test_rdw();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_wbuf.md
Name: sram_wbuf

Overview:
- Parametrised successor to the single 256x16 work RAM.
- Banked synchronous RAM with one CPU read port and two write sources: the SPI debug interface and the CPU.
- Debug writes keep absolute priority. A CPU write that collides with a debug write is queued in a small in-order write buffer instead of being dropped, and a stall flag is raised only when that buffer is full.
- Sits between the top-level address decode and the CPU/debug buses; replaces the per-bank sram instances and the debug/CPU write mux.

Parameters:
DWIDTH, 16, data word width in bits
BANK_AW, 8, address bits per bank (bank depth = 2^BANK_AW)
NBANKS, 2, number of banks (power of 2, 1..16)
WBDEPTH, 2, CPU write-buffer entries (power of 2, 1..8)
RDW_NEW, 0, read-during-write to same address: 0 = return old data, 1 = return new data
BYPASS, 1, 1 = reads are forwarded from pending write-buffer entries

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dbg_we  in  1  debug write strobe
dbg_waddr  in  AW  debug write address, where AW = BANK_AW + log2(NBANKS)
dbg_wdata  in  DWIDTH  debug write data
cpu_we  in  1  CPU write request
cpu_waddr  in  AW  CPU write address
cpu_wdata  in  DWIDTH  CPU write data
cpu_wstall  out  1  write buffer full; a CPU write offered this cycle is not accepted
re  in  1  read enable
raddr  in  AW  read address
rdata  out  DWIDTH  read data
rvalid  out  1  rdata updated this cycle
wb_count  out  log2(WBDEPTH)+1  write-buffer occupancy

Behaviour:
- Address map
  - Bank = addr[AW-1:BANK_AW]; word = addr[BANK_AW-1:0].
  - Each bank is a DWIDTH x 2^BANK_AW array that infers one EBR block.
  - Exactly one bank write-enable is active per committed write.
- Commit rule: at most one array write per cycle. Priority order:
  - dbg_we;
  - else head of the write buffer, if wb_count > 0;
  - else a direct CPU write (cpu_we, buffer empty).
- CPU acceptance
  - A CPU write is accepted when cpu_we=1 and cpu_wstall=0.
  - An accepted write goes straight to the array only if dbg_we=0 and wb_count=0. Otherwise it is pushed at the buffer tail.
  - cpu_wstall = (wb_count == WBDEPTH). It is combinational from the registered count.
  - The CPU holds address, data and cpu_we while stalled.
- Push and pop
  - Push and pop may occur in the same cycle; wb_count is then unchanged.
  - When full with dbg_we=0: pop occurs, push is refused that cycle, and the stall clears the next cycle.
- Ordering
  - CPU writes commit in acceptance order.
  - A debug write commits before any CPU write still pending at that cycle, so a buffered CPU write to the same address wins.
  - Continuous dbg_we starves the buffer; this is permitted.
- Read latency
  - re=1 in cycle N samples raddr. rdata is valid in cycle N+1 with rvalid=1 for exactly one cycle.
  - With re=0, rdata holds its last value and rvalid=0.
- Read-during-write to the same address in the same cycle
  - RDW_NEW=0: rdata is the old contents.
  - RDW_NEW=1: rdata is the data being committed.
- BYPASS=1: if raddr matches one or more pending buffer entries at the sample cycle, rdata is the newest matching entry's data. This overrides both the array and RDW.
- Reset
  - wb_count=0, cpu_wstall=0, rvalid=0, rdata=0.
  - Pending buffer entries are discarded and not committed.
  - Array contents are not cleared.
  - A write presented in the reset cycle is not committed.

Test Plan:
- Direct write then read: CPU writes 0x1234 to addr 0x005; re at 0x005 one cycle later -> rdata=0x1234 next cycle, rvalid=1, wb_count stays 0.
- Collision: dbg 0x0AAA and cpu 0x0BBB both write addr 0x010 in the same cycle -> wb_count=1, next cycle buffer drains, final read of 0x010 = 0x0BBB.
- Fill and stall (WBDEPTH=2): dbg_we held 4 cycles while the CPU writes 0x100,0x101,0x102 -> cpu_wstall=1 from cycle 3 to release, wb_count=2, all three addresses read back correct after dbg_we drops.
- Bypass: buffer holds 0x0C0 -> 0x5555; read 0x0C0 while pending -> rdata=0x5555. With BYPASS=0 -> old array value.
- RDW: write 0x7777 to 0x020 (old 0x1111) with a read of 0x020 in the same cycle -> rdata=0x1111 for RDW_NEW=0, 0x7777 for RDW_NEW=1.
- Reset mid-drain: wb_count=2, assert reset one cycle -> wb_count=0, rvalid=0, rdata=0, buffered addresses keep their prior contents.
